// File: rtl/fragment_issue_throttle_pkg.sv
// Shared rasterizer constants for the fragment path.
// Payload = framebuffer index + rasterizer parameter bits.
package RasterizerDefines;

  localparam int FRAMEBUFFER_INDEX_WIDTH        = 14;
  localparam int RASTERIZER_AXIS_PARAMETER_SIZE = 32;
  localparam int DEFAULT_ISSUE_INTERVAL         = 2;

endpackage

// File: rtl/fragment_issue_throttle_skid.sv
// axis_skid_buffer: 2-entry fall-through skid, registered ready,
// tlast carried with data; occ reports stored entries.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 46
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occ
);

  typedef logic [DATA_WIDTH:0] beat_t;

  beat_t      mem_q [2];
  beat_t      mem_d [2];
  beat_t      head;
  logic [1:0] occ_q, occ_d;
  logic       rdy_q, rdy_d;
  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  logic       empty, in_hs, out_hs;
  logic       store, pop;

  assign empty   = occ_q == 2'd0;
  assign in_hs   = s_valid & rdy_q;
  // empty skid presents the incoming beat directly
  assign head    = empty ? {s_last, s_data} : mem_q[rp_q];
  assign m_valid = !empty | in_hs;
  assign out_hs  = m_valid & m_ready;
  assign store   = in_hs & !(empty & out_hs);
  assign pop     = out_hs & !empty;

  assign {m_last, m_data} = head;
  assign s_ready = rdy_q;
  assign occ     = occ_q;

  always_comb begin
    mem_d = mem_q;
    if (store) mem_d[wp_q] = {s_last, s_data};
    wp_d  = wp_q ^ store;
    rp_d  = rp_q ^ pop;
    occ_d = occ_q + {1'b0, store} - {1'b0, pop};
    rdy_d = occ_d != 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      occ_q    <= 2'd0;
      rdy_q    <= 1'b0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
      rdy_q <= rdy_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end

endmodule

// File: rtl/fragment_issue_throttle.sv
// Issue-slot throttle: skid input, free-running slot counter,
// output register that issues only when slotOpen.
module fragment_issue_throttle
  import RasterizerDefines::*;
#(
  parameter int DATA_WIDTH   = FRAMEBUFFER_INDEX_WIDTH
                             + RASTERIZER_AXIS_PARAMETER_SIZE,
  parameter int MAX_INTERVAL = 4,
  parameter int CNT_WIDTH    = $clog2(MAX_INTERVAL + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_WIDTH-1:0]  confIssueInterval,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  slotOpen,
  output logic                  busy
);

  function automatic logic [CNT_WIDTH-1:0] clamp_interval(
    input logic [CNT_WIDTH-1:0] v
  );
    if (v == '0) return CNT_WIDTH'(1);
    if (v > CNT_WIDTH'(MAX_INTERVAL)) return CNT_WIDTH'(MAX_INTERVAL);
    return v;
  endfunction

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  act_q, act_d;
  logic                  ov_q, ov_d;
  logic                  olast_q, olast_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;

  logic                  sk_valid, sk_ready, sk_last;
  logic [DATA_WIDTH-1:0] sk_data;
  logic [1:0]            sk_occ;
  logic                  wrap, xfer, load;

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .s_last  (s_axis_tlast),
    .s_data  (s_axis_tdata),
    .m_valid (sk_valid),
    .m_ready (sk_ready),
    .m_last  (sk_last),
    .m_data  (sk_data),
    .occ     (sk_occ)
  );

  assign slotOpen = cnt_q == '0;
  // interval is only re-sampled at a period boundary
  assign wrap     = cnt_q == act_q - CNT_WIDTH'(1);
  assign xfer     = slotOpen & ov_q & m_axis_tready;
  assign sk_ready = !ov_q | xfer;
  assign load     = sk_valid & sk_ready;

  assign m_axis_tvalid = ov_q & slotOpen;
  assign m_axis_tlast  = olast_q;
  assign m_axis_tdata  = odata_q;
  assign busy          = ov_q | (sk_occ != 2'd0);

  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
    act_d   = wrap ? clamp_interval(confIssueInterval) : act_q;
    ov_d    = load | (ov_q & !xfer);
    olast_d = load ? sk_last : olast_q;
    odata_d = load ? sk_data : odata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      act_q   <= CNT_WIDTH'(1);
      ov_q    <= 1'b0;
      olast_q <= 1'b0;
      odata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      ov_q    <= ov_d;
      olast_q <= olast_d;
      odata_q <= odata_d;
    end
  end

endmodule
